nios2_ocimem_access_arbiter: RTL
================================

Name: nios2_ocimem_access_arbiter

Overview:
- Shares the single OCI debug-memory port (on-chip debug RAM/registers) between two requesters.
  - JTAG debug side: pulse-based commands decoded from the take_action ocimem strobes and jdo.
  - CPU side: an Avalon-MM debug slave.
- Sequences each access: fixed read latency, JTAG command buffering, address auto-increment, bounded Avalon starvation.
- Sits in the clk domain between the debug module's sysclk logic and the OCI memory.

Parameters:
- ADDR_W, 8, OCI memory word-address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles (legal 1..3).
- MAX_WAIT, 4, number of cycles a pending Avalon request may lose arbitration before it is forced to win.

Ports:
- clk  in  1  system clock; everything synchronous to clk.
- reset  in  1  synchronous, active-high reset.
- jtag_cmd_valid  in  1  single-cycle command pulse.
- jtag_cmd_wr  in  1  1 = write, 0 = read.
- jtag_cmd_load_addr  in  1  1 = use jtag_cmd_addr; 0 = use the auto-increment pointer.
- jtag_cmd_addr  in  ADDR_W  explicit address.
- jtag_cmd_wdata  in  DATA_W  write data.
- jtag_rdata  out  DATA_W  last JTAG read data (MonDReg source).
- jtag_done  out  1  one-cycle completion pulse.
- jtag_overrun  out  1  sticky: a command was dropped.
- jtag_overrun_clr  in  1  clears jtag_overrun.
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_address  in  ADDR_W  Avalon address.
- avs_writedata  in  DATA_W  Avalon write data.
- avs_readdata  out  DATA_W  Avalon read data.
- avs_waitrequest  out  1  Avalon stall.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  valid RD_LAT cycles after mem_re.

Behaviour:
- Reset values:
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - jtag_rdata=0, jtag_done=0, jtag_overrun=0.
  - avs_readdata=0, avs_waitrequest=1.
  - State IDLE, JTAG holding register empty, address pointer 0, wait counter 0.
- JTAG holding register (1 entry):
  - On jtag_cmd_valid with the register empty, or being granted that same cycle: capture wr, wdata, and addr = load_addr ? jtag_cmd_addr : ptr.
  - At capture, ptr <= addr+1, modulo 2^ADDR_W (so 0xFF wraps to 0x00 at ADDR_W=8).
  - On jtag_cmd_valid with the register full and not being granted: drop the command, set jtag_overrun; ptr is unchanged.
  - jtag_overrun_clr clears the flag; if set and clear occur in the same cycle, set wins.
- Avalon request = avs_read | avs_write.
  - Master holds signals stable while stalled.
  - read & write together is treated as a write.
- avs_waitrequest = 1 except for exactly one cycle, the DONE cycle of an Avalon access; it is also 1 when no request is present.
- FSM: IDLE -> ISSUE -> RDWAIT (reads only) -> DONE -> IDLE.
  - IDLE: if only one requester is pending, grant it.
    - If both are pending, grant JTAG unless wait_cnt == MAX_WAIT, in which case grant Avalon.
    - On grant, latch addr/wdata/wr/owner into the active registers and go to ISSUE.
  - ISSUE (1 cycle): drive mem_addr and mem_wdata, and pulse mem_we or mem_re.
    - Write -> DONE.
    - Read -> RDWAIT.
  - RDWAIT: count RD_LAT cycles, then capture mem_rdata into the owner's read register (jtag_rdata or avs_readdata) and go to DONE.
  - DONE (1 cycle):
    - JTAG owner: jtag_done=1.
    - Avalon owner: avs_waitrequest=0, avs_readdata valid.
- Latency: with grant in cycle G, the strobe is at G+1; DONE is at G+2 for writes and G+2+RD_LAT for reads.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, in each IDLE cycle where an Avalon request is pending and JTAG is granted.
  - Cleared when Avalon is granted or no Avalon request is pending.
- No back-to-back grants: IDLE is always visited between accesses. mem_we and mem_re are never both 1.
- Reset mid-access: abandon the access. The next cycle has strobes 0, state IDLE, and the holding register empty. No done pulse and no waitrequest drop for the abandoned access.

Test Plan:
- JTAG write with load_addr=1, addr=0x10, wdata=0xDEADBEEF, then a read with load_addr=0 -> mem_we at G+1 with mem_addr=0x10. The read issues at addr 0x11; with RD_LAT=1 and mem_rdata=0x12345678, jtag_rdata=0x12345678 on the jtag_done pulse.
- Pointer wrap: load_addr=1, addr=0xFF, then two auto-increment reads -> mem_addr sequence 0xFF, 0x00, 0x01.
- Overrun: three jtag_cmd_valid pulses on consecutive cycles while an Avalon read is in RDWAIT -> the first is held, the second and third are dropped, jtag_overrun=1. jtag_overrun_clr then clears it. Set and clr in the same cycle leaves it 1.
- Starvation: avs_read held at 0x20 while JTAG issues a command every 4 cycles (ptr reads) -> Avalon is granted at the latest after MAX_WAIT=4 JTAG wins. avs_waitrequest is low for exactly one cycle with the correct data.
- Avalon write 0x05 <- 0xA5A5A5A5 alone -> avs_waitrequest is low at G+2 only; mem_we is a single pulse.
- Reset asserted the cycle after mem_re (RD_LAT=3) -> no jtag_done; all outputs at reset values; the next command completes normally.

Source files
------------

// File: rtl/nios2_ocimem_access_arbiter.sv
// Arbiter sharing the OCI debug-memory port between JTAG debug commands and
// the CPU-side Avalon-MM debug slave: one-entry JTAG command buffer with
// address auto-increment, fixed read latency, bounded Avalon starvation.
module nios2_ocimem_access_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_cmd_valid,
    input  logic              jtag_cmd_wr,
    input  logic              jtag_cmd_load_addr,
    input  logic [ADDR_W-1:0] jtag_cmd_addr,
    input  logic [DATA_W-1:0] jtag_cmd_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overrun,
    input  logic              jtag_overrun_clr,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LAT_W  = 2;
    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // JTAG holding register and auto-increment pointer
    logic              hold_valid;
    logic              hold_wr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [ADDR_W-1:0] ptr;

    // Active-access bookkeeping (address/wdata live directly in mem_addr/mem_wdata)
    logic              act_wr;
    logic              act_avs;
    logic [LAT_W-1:0]  lat_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    // Combinational decode
    logic              avs_req_c;
    logic              jtag_grant_c;
    logic              avs_grant_c;
    logic              cap_c;
    logic              drop_c;
    logic [ADDR_W-1:0] cap_addr_c;
    logic              rd_cap_c;
    logic              mem_we_nx_c;
    logic              mem_re_nx_c;
    logic              jtag_done_nx_c;
    logic              waitreq_nx_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Arbitration, next state and next registered outputs
    always_comb begin
        state_nx       = state;
        avs_req_c      = avs_read | avs_write;
        jtag_grant_c   = 1'b0;
        avs_grant_c    = 1'b0;
        rd_cap_c       = 1'b0;
        mem_we_nx_c    = 1'b0;
        mem_re_nx_c    = 1'b0;
        cap_c          = jtag_cmd_valid;
        drop_c         = 1'b0;
        cap_addr_c     = jtag_cmd_load_addr ? jtag_cmd_addr : ptr;

        if (state == IDLE) begin
            if (hold_valid && avs_req_c) begin
                if (wait_cnt == WAIT_W'(MAX_WAIT)) avs_grant_c  = 1'b1;
                else                               jtag_grant_c = 1'b1;
            end else if (hold_valid) begin
                jtag_grant_c = 1'b1;
            end else if (avs_req_c) begin
                avs_grant_c = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (jtag_grant_c) begin
                    state_nx    = ISSUE;
                    mem_we_nx_c = hold_wr;
                    mem_re_nx_c = ~hold_wr;
                end else if (avs_grant_c) begin
                    state_nx    = ISSUE;
                    mem_we_nx_c = avs_write;
                    mem_re_nx_c = ~avs_write;
                end
            end
            ISSUE:   state_nx = act_wr ? DONE : RDWAIT;
            RDWAIT: begin
                if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                    rd_cap_c = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // A full buffer only accepts a new command in the cycle it is drained
        cap_c          = jtag_cmd_valid && (!hold_valid || jtag_grant_c);
        drop_c         = jtag_cmd_valid && !cap_c;
        jtag_done_nx_c = (state_nx == DONE) && !act_avs;
        waitreq_nx_c   = !((state_nx == DONE) && act_avs);
    end

    // JTAG command buffer, pointer and overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid   <= 1'b0;
            hold_wr      <= 1'b0;
            hold_addr    <= '0;
            hold_wdata   <= '0;
            ptr          <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (cap_c) begin
                hold_valid <= 1'b1;
                hold_wr    <= jtag_cmd_wr;
                hold_addr  <= cap_addr_c;
                hold_wdata <= jtag_cmd_wdata;
                ptr        <= cap_addr_c + ADDR_W'(1);
            end else if (jtag_grant_c) begin
                hold_valid <= 1'b0;
            end
            if (drop_c)                jtag_overrun <= 1'b1;
            else if (jtag_overrun_clr) jtag_overrun <= 1'b0;
        end
    end

    // Avalon starvation counter
    always_ff @(posedge clk) begin
        if (reset)                           wait_cnt <= '0;
        else if (!avs_req_c || avs_grant_c)  wait_cnt <= '0;
        else if (jtag_grant_c && wait_cnt != WAIT_W'(MAX_WAIT))
                                             wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Active access, memory strobes, read-data capture and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            act_wr          <= 1'b0;
            act_avs         <= 1'b0;
            lat_cnt         <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_we          <= 1'b0;
            mem_re          <= 1'b0;
            jtag_rdata      <= '0;
            jtag_done       <= 1'b0;
            avs_readdata    <= '0;
            avs_waitrequest <= 1'b1;
        end else begin
            if (jtag_grant_c) begin
                act_wr    <= hold_wr;
                act_avs   <= 1'b0;
                mem_addr  <= hold_addr;
                mem_wdata <= hold_wdata;
            end else if (avs_grant_c) begin
                act_wr    <= avs_write;
                act_avs   <= 1'b1;
                mem_addr  <= avs_address;
                mem_wdata <= avs_writedata;
            end
            lat_cnt <= (state == RDWAIT) ? lat_cnt + LAT_W'(1) : '0;
            if (rd_cap_c) begin
                if (act_avs) avs_readdata <= mem_rdata;
                else         jtag_rdata   <= mem_rdata;
            end
            mem_we          <= mem_we_nx_c;
            mem_re          <= mem_re_nx_c;
            jtag_done       <= jtag_done_nx_c;
            avs_waitrequest <= waitreq_nx_c;
        end
    end

endmodule
